// File: rtl/key_event_scheduler_if.sv
// Bus bundle for key_event_scheduler: PIO-side Avalon master plus CPU-side Avalon slave.
// "master" is the scheduler's view; "slave" is the environment's view.
interface key_event_scheduler_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]    irq_in;
    logic [N_CH-1:0]    m_chipselect;
    logic [1:0]         m_address;
    logic               m_write_n;
    logic [31:0]        m_writedata;
    logic [N_CH*32-1:0] m_readdata;
    logic               s_chipselect;
    logic               s_read;
    logic               s_write_n;
    logic [1:0]         s_address;
    logic [31:0]        s_writedata;
    logic [31:0]        s_readdata;
    logic               irq_out;

    modport master (
        input  irq_in, m_readdata, s_chipselect, s_read, s_write_n, s_address, s_writedata,
        output m_chipselect, m_address, m_write_n, m_writedata, s_readdata, irq_out
    );
    modport slave (
        output irq_in, m_readdata, s_chipselect, s_read, s_write_n, s_address, s_writedata,
        input  m_chipselect, m_address, m_write_n, m_writedata, s_readdata, irq_out
    );
endinterface

// File: rtl/key_event_scheduler.sv
// Services edge-capture key PIOs round-robin and queues one event per channel for the CPU.
// Optional TIMESTAMP_EN: latch a free-running counter at ARB into entry bits [8+TS_WIDTH-1:8].
module key_event_scheduler #(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16
) (
    input logic                   clk,
    input logic                   reset_n,
    key_event_scheduler_if.master bus
);
    localparam int PW = $clog2(N_CH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, ARB, READ, WAIT, CLEAR, PUSH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, arb_idx;
    logic            arb_hit, cap_q, cap_d;
    logic [N_CH-1:0] enable_q, enable_d, pending;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d, irq_q, irq_d;
    logic [31:0]     rdata_q, rdata_d, entry;
    logic            empty, full, cpu_rd, cpu_wr, want_push, push, pop, drop;
    int              idx;
    logic            unused_bits;

    assign unused_bits = ^{bus.s_writedata, bus.m_readdata};

    // Search from rr_ptr+1 with wrap; the loop runs backwards so the nearest hit wins.
    always_comb begin
        pending = bus.irq_in & enable_q;
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (int'(rr_ptr_q) + i) % N_CH;
            if (pending[idx]) begin
                arb_hit = 1'b1;
                arb_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending) state_d = ARB;
            ARB:     state_d = arb_hit ? READ : IDLE;
            READ:    state_d = WAIT;
            WAIT:    state_d = CLEAR;
            CLEAR:   state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master outputs decode straight from state so a reset idles the bus at once.
    always_comb begin
        bus.m_chipselect = '0;
        bus.m_address    = 2'd0;
        bus.m_write_n    = 1'b1;
        bus.m_writedata  = 32'h0;
        if (state_q == READ || state_q == CLEAR) begin
            bus.m_chipselect[grant_q] = 1'b1;
            bus.m_address             = 2'd3;
            bus.m_write_n             = (state_q != CLEAR);
        end
    end

`ifdef TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d, ts_lat_q, ts_lat_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
        ts_lat_d = (state_q == ARB) ? ts_cnt_q : ts_lat_q;
        entry    = 32'h8000_0000 | 32'(grant_q);
        entry[8 +: TS_WIDTH] = ts_lat_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_lat_q <= ts_lat_d;
        end
    end
`else
    always_comb entry = 32'h8000_0000 | 32'(grant_q);
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    always_comb begin
        cpu_rd    = bus.s_chipselect & bus.s_read;
        cpu_wr    = bus.s_chipselect & ~bus.s_write_n;
        pop       = cpu_rd && bus.s_address == 2'd0 && !empty;
        want_push = (state_q == PUSH) && cap_q;
        // A same-cycle pop frees the slot the push needs.
        push      = want_push && (!full || pop);
        drop      = want_push && !push;

        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB && arb_hit) begin
            grant_d  = arb_idx;
            rr_ptr_d = arb_idx;
        end
        cap_d = (state_q == WAIT) ? bus.m_readdata[32*int'(grant_q)] : cap_q;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = entry;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        ovf_d = ovf_q;
        if (cpu_wr && bus.s_address == 2'd3) ovf_d = 1'b0;
        if (drop)                            ovf_d = 1'b1;

        enable_d = enable_q;
        if (cpu_wr && bus.s_address == 2'd2) enable_d = bus.s_writedata[N_CH-1:0];

        rdata_d = rdata_q;
        if (cpu_rd) begin
            case (bus.s_address)
                2'd0:    rdata_d = empty ? 32'h0 : mem_q[rd_ptr_q];
                2'd1:    rdata_d = {21'b0, ovf_q, full, empty, 8'(count_q)};
                2'd2:    rdata_d = 32'(enable_q);
                default: rdata_d = 32'h0;
            endcase
        end
        irq_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= PW'(N_CH - 1);
            grant_q  <= '0;
            cap_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            enable_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cap_q    <= cap_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.s_readdata = rdata_q;
    assign bus.irq_out    = irq_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: four edge-capture PIO models plus a CPU driver.
module tb_key_event_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    key_event_scheduler_if #(.N_CH(4)) bus ();

    key_event_scheduler #(.N_CH(4), .FIFO_DEPTH(8), .TS_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_q [$];
    string       tag_q [$];
    logic [31:0] cs_q [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endfunction

    // PIO models: registered readdata, capture cleared by a write to address 3.
    logic [3:0] pio_cap = '0;
    logic [3:0] set_mask = '0;
    logic       kill = 1'b0;
    int         clr_cnt [4];
    assign bus.irq_in = pio_cap;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bus.m_readdata[i*32 +: 32] <= (bus.m_chipselect[i] && bus.m_write_n && bus.m_address == 2'd3)
                                          ? {31'b0, pio_cap[i]} : 32'h0;
            if (kill) begin
                pio_cap[i] <= 1'b0;
                clr_cnt[i] <= 0;
            end else if (bus.m_chipselect[i] && !bus.m_write_n && bus.m_address == 2'd3
                         && bus.m_writedata == 32'h0) begin
                pio_cap[i] <= 1'b0;
                clr_cnt[i] <= clr_cnt[i] + 1;
            end else if (set_mask[i]) begin
                pio_cap[i] <= 1'b1;
            end
        end
    end

    // Monitor: compares CPU read data and PIO read strobes against queued expectations.
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= bus.s_chipselect & bus.s_read;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected got=%h want=none", bus.s_readdata);
            end else begin
                check(tag_q.pop_front(), bus.s_readdata, rd_q.pop_front());
            end
        end
        if (bus.m_chipselect != 4'b0 && bus.m_write_n) begin
            if (cs_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pio_read_unexpected got=%h want=none", bus.m_chipselect);
            end else begin
                check("pio_read_sel", 32'({bus.m_address, bus.m_chipselect}), cs_q.pop_front());
            end
        end
    end

    task automatic cpu_idle();
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write_n = 1'b1;
        bus.s_address = 2'd0; bus.s_writedata = 32'h0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bus.s_chipselect = 1'b1; bus.s_write_n = 1'b0; bus.s_address = a; bus.s_writedata = d;
        @(negedge clk);
        cpu_idle();
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        tag_q.push_back(name);
        bus.s_chipselect = 1'b1; bus.s_read = 1'b1; bus.s_address = a;
        @(negedge clk);
        cpu_idle();
    endtask

    task automatic do_reset();
        cpu_idle();
        reset_n = 1'b0; kill = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; kill = 1'b0;
        @(negedge clk);
    endtask

    task automatic pio_set(input logic [3:0] m);
        set_mask = m;
        @(negedge clk);
        set_mask = '0;
    endtask

    // One full service of channel ch, expecting a PIO read on that channel.
    task automatic service(input int ch, input string name);
        logic [3:0] m;
        m = 4'b0001 << ch;
        cs_q.push_back(32'({2'd3, m}));
        pio_set(m);
        for (int k = 0; k < 50 && pio_cap[ch]; k++) @(negedge clk);
        check(name, 32'(pio_cap[ch]), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        cpu_idle();
        do_reset();

        // Reset state and single event on channel 2.
        check("rst_readdata", bus.s_readdata, 32'h0);
        check("rst_irq", 32'(bus.irq_out), 32'd0);
        check("rst_cs", 32'(bus.m_chipselect), 32'd0);
        check("rst_write_n", 32'(bus.m_write_n), 32'd1);
        cpu_read(2'd1, 32'h100, "rst_status");
        cpu_read(2'd2, 32'h0, "rst_enable");
        cpu_write(2'd2, 32'hF);
        cpu_read(2'd2, 32'hF, "t1_enable");
        cs_q.push_back(32'({2'd3, 4'b0100}));
        pio_set(4'b0100);
        for (int k = 0; k < 50 && !bus.irq_out; k++) @(negedge clk);
        check("t1_irq_high", 32'(bus.irq_out), 32'd1);
        check("t1_clears", 32'(clr_cnt[2]), 32'd1);
        cpu_read(2'd0, 32'h8000_0002, "t1_pop");
        cpu_read(2'd1, 32'h100, "t1_status");
        @(negedge clk);
        check("t1_irq_low", 32'(bus.irq_out), 32'd0);
        cpu_read(2'd0, 32'h0, "t1_pop_empty");

        // All four held: round-robin from rr_ptr=3 gives 0,1,2,3.
        do_reset();
        cpu_write(2'd2, 32'hF);
        for (int i = 0; i < 4; i++) cs_q.push_back(32'({2'd3, 4'b0001 << i}));
        pio_set(4'b1111);
        for (int k = 0; k < 100 && pio_cap != 4'b0; k++) @(negedge clk);
        check("t2_all_cleared", 32'(pio_cap), 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) cpu_read(2'd0, 32'h8000_0000 | 32'(i), "t2_pop_order");
        cpu_read(2'd1, 32'h100, "t2_status");

        // Masked channel: nothing happens.
        do_reset();
        cpu_write(2'd2, 32'h5);
        pio_set(4'b0010);
        repeat (20) @(negedge clk);
        check("t3_no_clear", 32'(clr_cnt[1]), 32'd0);
        check("t3_still_pending", 32'(pio_cap[1]), 32'd1);
        check("t3_irq", 32'(bus.irq_out), 32'd0);
        cpu_read(2'd1, 32'h100, "t3_status");

        // Nine events into an 8-deep FIFO: overflow, then clear it.
        do_reset();
        cpu_write(2'd2, 32'hF);
        for (int e = 0; e < 9; e++) service(e % 4, "t4_service");
        check("t4_clear_total", 32'(clr_cnt[0] + clr_cnt[1] + clr_cnt[2] + clr_cnt[3]), 32'd9);
        cpu_read(2'd1, 32'h608, "t4_status_ovf");
        cpu_write(2'd3, 32'h0);
        cpu_read(2'd1, 32'h208, "t4_status_clr");
        cpu_read(2'd0, 32'h8000_0000, "t4_pop_first");

        // Pop coinciding with a push at count 3.
        do_reset();
        cpu_write(2'd2, 32'hF);
        for (int e = 0; e < 3; e++) service(e, "t5_service");
        cs_q.push_back(32'({2'd3, 4'b1000}));
        pio_set(4'b1000);
        for (int k = 0; k < 50 && bus.m_write_n; k++) @(negedge clk);
        check("t5_clear_seen", 32'(bus.m_write_n), 32'd0);
        @(negedge clk);
        cpu_read(2'd0, 32'h8000_0000, "t5_pop_with_push");
        cpu_read(2'd1, 32'h003, "t5_count");
        for (int i = 1; i < 4; i++) cpu_read(2'd0, 32'h8000_0000 | 32'(i), "t5_pop_rest");

        // Reset asserted during WAIT.
        do_reset();
        cpu_write(2'd2, 32'hF);
        cs_q.push_back(32'({2'd3, 4'b0010}));
        pio_set(4'b0010);
        for (int k = 0; k < 50 && bus.m_chipselect == 4'b0; k++) @(negedge clk);
        check("t6_read_seen", 32'(bus.m_chipselect), 32'h2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_cs_idle", 32'(bus.m_chipselect), 32'd0);
        check("t6_wn_idle", 32'(bus.m_write_n), 32'd1);
        check("t6_addr_idle", 32'(bus.m_address), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_clear", 32'(clr_cnt[1]), 32'd0);
        check("t6_irq", 32'(bus.irq_out), 32'd0);
        cpu_read(2'd1, 32'h100, "t6_status");

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("pio_queue_drained", 32'(cs_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
